// File: rtl/round_key_store.sv
// round_key_store: in-order key word store serving registered 4-word round keys, stalling until a round is written.
module round_key_store #(
  parameter int WORD_W = 32,
  parameter int NUM_WORDS = 44,
  localparam int NUM_ROUNDS = NUM_WORDS / 4,
  localparam int CNT_W = $clog2(NUM_WORDS + 1),
  localparam int RND_W = $clog2(NUM_ROUNDS)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clear_i,
  input  logic                wr_en_i,
  input  logic [WORD_W-1:0]   wr_data_i,
  input  logic                rd_req_i,
  input  logic [RND_W-1:0]    rd_round_i,
  output logic                rd_ready_o,
  output logic                rd_valid_o,
  output logic [4*WORD_W-1:0] rd_key_o,
  output logic                rd_err_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                full_o
);
  localparam int IW = $clog2(NUM_WORDS);
  localparam int AW = (CNT_W > RND_W + 3) ? CNT_W : RND_W + 3;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [RND_W-1:0] rnd_q, rnd_d, sel;
  logic [4*WORD_W-1:0] key_q, key_d;
  logic err_q, err_d;
  logic [WORD_W-1:0] mem_q [NUM_WORDS];
  logic full, wr, in_range, avail;
  assign full = count_q == CNT_W'(NUM_WORDS);
  assign wr = wr_en_i && !full && !clear_i;
  // IDLE evaluates the incoming request; WAIT re-evaluates the latched one
  assign sel = (state_q == S_IDLE) ? rd_round_i : rnd_q;
  assign in_range = AW'(sel) < AW'(NUM_ROUNDS);
  assign avail = AW'(count_q) >= AW'({sel, 2'b00}) + AW'(4);
  for (genvar k = 0; k < 4; k++) begin : g_key
    assign key_d[(4-k)*WORD_W-1 -: WORD_W] = mem_q[IW'({sel, 2'(k)})];
  end
  always_comb begin
    state_d = state_q;
    rnd_d = rnd_q;
    err_d = 1'b0;
    if (clear_i) state_d = S_IDLE;
    else if (state_q == S_IDLE && rd_req_i) begin
      rnd_d = rd_round_i;
      err_d = !in_range;
      state_d = !in_range ? S_IDLE : avail ? S_OUT : S_WAIT;
    end
    else if (state_q == S_WAIT && avail) state_d = S_OUT;
    else if (state_q == S_OUT) state_d = S_IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rnd_q <= '0;
      key_q <= '0;
      err_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      rnd_q <= rnd_d;
      err_q <= err_d;
      if (state_d == S_OUT) key_q <= key_d;
      if (clear_i) count_q <= '0;
      else if (wr) begin
        mem_q[IW'(count_q)] <= wr_data_i;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end
  assign rd_ready_o = state_q == S_IDLE;
  assign rd_valid_o = state_q == S_OUT;
  assign rd_key_o = key_q;
  assign rd_err_o = err_q;
  assign count_o = count_q;
  assign full_o = full;
endmodule

// File: doc/round_key_store.md
# round_key_store

Parametrised round-key buffer for the KeyExpansion path. It accepts expanded key words one per cycle from the expansion datapath. It serves registered 4-word round keys to the cipher rounds by round index, and stalls a request until that round's words exist. It replaces fixed 8-way word selection with a deep, handshaked, wait-capable store sized for AES-128/192/256.

## Interface
- WORD_W, 32, key word width in bits
- NUM_WORDS, 44, words stored (44/52/60 for AES-128/192/256); multiple of 4, ≥ 8
- Derived: NUM_ROUNDS = NUM_WORDS/4; CNT_W = $clog2(NUM_WORDS+1); RND_W = $clog2(NUM_ROUNDS)

- Clk  in  1  clock, all state on rising edge
- Rst_n  in  1  asynchronous active-low reset
- Clear  in  1  synchronous flush of stored key (new key load)
- Wr_En  in  1  write strobe for Wr_Data
- Wr_Data  in  WORD_W  next expanded key word, written in order w[0], w[1], …
- Rd_Req  in  1  round-key request, sampled only when Rd_Ready=1
- Rd_Round  in  RND_W  requested round index r
- Rd_Ready  out  1  block can accept a request
- Rd_Valid  out  1  one-cycle pulse: Rd_Key holds round r
- Rd_Key  out  4*WORD_W  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in MSBs
- Rd_Err  out  1  one-cycle pulse: request out of range
- Count  out  CNT_W  words stored so far
- Full  out  1  Count == NUM_WORDS

## Operation
- Storage: NUM_WORDS × WORD_W registers. Write pointer equals Count.
- Write: Wr_En=1 and Full=0 stores Wr_Data at w[Count] and increments Count. Wr_En while Full is ignored: no wrap, no overwrite.
- Clear: Count←0 and FSM→IDLE. Storage contents are not cleared. Clear has priority over a same-cycle write, which is dropped.
- Round r is available when Count (registered, pre-write value) ≥ 4r+4.
- FSM states:
  - IDLE: Rd_Ready=1. On Rd_Req, latch r.
    - r ≥ NUM_ROUNDS: pulse Rd_Err next cycle, stay IDLE.
    - r available: go to OUT.
    - Otherwise: go to WAIT.
  - WAIT: Rd_Ready=0. Check availability every cycle against the latched r. Go to OUT when available. Clear → IDLE with no Rd_Valid.
  - OUT: load Rd_Key, assert Rd_Valid for exactly one cycle, then return to IDLE. Rd_Ready=0 while in OUT.
- Rd_Key holds its last value between reads. Only OUT updates it.
- Writes continue in every FSM state.

## Timing
- Reset (Rst_n=0, async):
  - Count=0, Full=0, FSM=IDLE, Rd_Ready=1, Rd_Valid=0, Rd_Err=0, Rd_Key=0.
  - Storage is reset to 0.
- Hit latency: request accepted at edge t → Rd_Valid=1 and Rd_Key valid in cycle t+1 → Rd_Ready=1 again in cycle t+2. Maximum rate is one read every 2 cycles.
- Miss: when the write that makes Count reach 4r+4 lands at edge t, WAIT sees availability in cycle t+1 and Rd_Valid pulses in cycle t+2.
- Same-cycle write and request for a round completed by that write: treated as a miss (pre-write Count). Valid data arrives 2 cycles later, never stale data.
- Rd_Err: asserted the cycle after acceptance for one cycle. Rd_Valid is not asserted for that request.
- Rst_n asserted mid-WAIT or mid-OUT: immediate IDLE. A pending Rd_Valid is never emitted.
- Count/Full: updated the cycle after the write edge. Full rises the cycle after word NUM_WORDS−1 is written.

## Test plan
- Reset then fill (NUM_WORDS=44): write w[i]=32'hA000_0000+i for 44 cycles → Count=44, Full=1. A 45th write → Count stays 44 and w[43] is unchanged.
- Hit read: after the fill, request r=10 → one cycle later Rd_Valid=1 and Rd_Key={A000_0028, A000_0029, A000_002A, A000_002B}. Rd_Ready returns to 1 the following cycle.
- Stall read: after writing 5 words, request r=1 → Rd_Ready=0 with no Rd_Valid. Write words 5–7 → Rd_Valid pulses 2 cycles after the w[7] write edge with Rd_Key={…0004,…0005,…0006,…0007}.
- Errors/boundaries:
  - r=11 (out of range) → Rd_Err pulse, no Rd_Valid, Rd_Ready stays 1.
  - r=0 with Count=3 → WAIT.
  - r=0 with Count=4 → hit.
- Abort: request r=5 with Count=8, then assert Clear → FSM back in IDLE, no Rd_Valid, Count=0. Repeat the abort with Rst_n pulsed low mid-WAIT → all outputs at their reset values.
- Param sweep: NUM_WORDS=60, WORD_W=32 → fill, then read r=14 → Rd_Key = words 56–59.
